// File: rtl/dec_freelist_module_pkg.sv
// Shared rename free-list types and core widths.
// Imported by the free-list interface, top and lane-offset logic.
package dec_freelist_module_pkg;

  localparam int PRF_CODE_WIDTH = 6;
  localparam int ARF_CODE_WIDTH = 5;
  localparam int CORE_FL_DEPTH  = 32;
  localparam int FL_LANES       = 4;
  localparam int FL_CNT_W       = $clog2(CORE_FL_DEPTH) + 1;

  typedef logic [PRF_CODE_WIDTH-1:0] prf_code_t;
  typedef logic [ARF_CODE_WIDTH-1:0] arf_code_t;
  typedef logic [FL_CNT_W-1:0]       fl_cnt_t;
  typedef logic [1:0]                lane_off_t;
  typedef logic [2:0]                lane_cnt_t;

  typedef struct packed {
    logic [FL_LANES-1:0]      vld;
    prf_code_t [FL_LANES-1:0] code;
  } fl_rel_t;

endpackage

// File: rtl/dec_freelist_module_if.sv
// Rename/retire ports of the physical-register free list.
// master drives requests, slave is the free list itself.
interface dec_freelist_module_if;
  import dec_freelist_module_pkg::*;

  logic      i_fl_alloc_vld_0;
  logic      i_fl_alloc_vld_1;
  logic      i_fl_alloc_vld_2;
  logic      i_fl_alloc_vld_3;
  logic      i_fl_alloc_en;
  prf_code_t o_fl_alloc_prf_code_0;
  prf_code_t o_fl_alloc_prf_code_1;
  prf_code_t o_fl_alloc_prf_code_2;
  prf_code_t o_fl_alloc_prf_code_3;
  logic      o_fl_alloc_rdy;
  logic      i_fl_rel_vld_0;
  logic      i_fl_rel_vld_1;
  logic      i_fl_rel_vld_2;
  logic      i_fl_rel_vld_3;
  prf_code_t i_fl_rel_prf_code_0;
  prf_code_t i_fl_rel_prf_code_1;
  prf_code_t i_fl_rel_prf_code_2;
  prf_code_t i_fl_rel_prf_code_3;
  logic      i_fl_flush;
  fl_cnt_t   o_fl_free_cnt;

  modport master (
    output i_fl_alloc_vld_0,
    output i_fl_alloc_vld_1,
    output i_fl_alloc_vld_2,
    output i_fl_alloc_vld_3,
    output i_fl_alloc_en,
    input  o_fl_alloc_prf_code_0,
    input  o_fl_alloc_prf_code_1,
    input  o_fl_alloc_prf_code_2,
    input  o_fl_alloc_prf_code_3,
    input  o_fl_alloc_rdy,
    output i_fl_rel_vld_0,
    output i_fl_rel_vld_1,
    output i_fl_rel_vld_2,
    output i_fl_rel_vld_3,
    output i_fl_rel_prf_code_0,
    output i_fl_rel_prf_code_1,
    output i_fl_rel_prf_code_2,
    output i_fl_rel_prf_code_3,
    output i_fl_flush,
    input  o_fl_free_cnt
  );

  modport slave (
    input  i_fl_alloc_vld_0,
    input  i_fl_alloc_vld_1,
    input  i_fl_alloc_vld_2,
    input  i_fl_alloc_vld_3,
    input  i_fl_alloc_en,
    output o_fl_alloc_prf_code_0,
    output o_fl_alloc_prf_code_1,
    output o_fl_alloc_prf_code_2,
    output o_fl_alloc_prf_code_3,
    output o_fl_alloc_rdy,
    input  i_fl_rel_vld_0,
    input  i_fl_rel_vld_1,
    input  i_fl_rel_vld_2,
    input  i_fl_rel_vld_3,
    input  i_fl_rel_prf_code_0,
    input  i_fl_rel_prf_code_1,
    input  i_fl_rel_prf_code_2,
    input  i_fl_rel_prf_code_3,
    input  i_fl_flush,
    output o_fl_free_cnt
  );

endinterface

// File: rtl/dec_freelist_module_lane_offset.sv
// 4-lane exclusive prefix count and total popcount.
// Packs sparse valid lanes onto consecutive free-list slots.
module dec_fl_lane_offset
  import dec_freelist_module_pkg::*;
(
  input  logic [FL_LANES-1:0]      vld,
  output lane_off_t [FL_LANES-1:0] off,
  output lane_cnt_t                cnt
);

  assign off[0] = 2'd0;
  assign off[1] = {1'b0, vld[0]};
  assign off[2] = 2'(vld[0]) + 2'(vld[1]);
  assign off[3] = off[2] + 2'(vld[2]);
  assign cnt    = {1'b0, off[3]} + 3'(vld[3]);

endmodule

// File: rtl/dec_freelist_module.sv
// Circular physical-register free list with speculative/commit heads.
// Flush rewinds the speculative head to the committed one.
module dec_freelist_module
  import dec_freelist_module_pkg::*;
#(
  parameter int FL_DEPTH = CORE_FL_DEPTH
) (
  input logic                  clk,
  input logic                  rst_n,
  dec_freelist_module_if.slave fl
);

  localparam int IDX_W = $clog2(FL_DEPTH);

  typedef logic [IDX_W:0]   ptr_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef prf_code_t [FL_DEPTH-1:0] entry_vec_t;

  function automatic entry_vec_t entry_rst();
    entry_vec_t v;
    for (int i = 0; i < FL_DEPTH; i++) begin
      v[i] = prf_code_t'(FL_DEPTH + i);
    end
    return v;
  endfunction

  localparam entry_vec_t ENTRY_RST = entry_rst();

  logic [FL_LANES-1:0]      alloc_vld;
  fl_rel_t                  rel;
  lane_off_t [FL_LANES-1:0] a_off;
  lane_off_t [FL_LANES-1:0] r_off;
  lane_cnt_t                a_cnt;
  lane_cnt_t                r_cnt;

  entry_vec_t entry_q;
  entry_vec_t entry_d;
  ptr_t       spec_head_q;
  ptr_t       spec_head_d;
  ptr_t       cmt_head_q;
  ptr_t       cmt_head_d;
  ptr_t       tail_q;
  ptr_t       tail_d;

  ptr_t      free_cnt;
  logic      alloc_rdy;
  logic      alloc_fire;
  idx_t      a_idx [FL_LANES];
  idx_t      r_idx [FL_LANES];
  prf_code_t grant [FL_LANES];

  assign alloc_vld = {
    fl.i_fl_alloc_vld_3,
    fl.i_fl_alloc_vld_2,
    fl.i_fl_alloc_vld_1,
    fl.i_fl_alloc_vld_0
  };

  assign rel = {
    fl.i_fl_rel_vld_3,
    fl.i_fl_rel_vld_2,
    fl.i_fl_rel_vld_1,
    fl.i_fl_rel_vld_0,
    fl.i_fl_rel_prf_code_3,
    fl.i_fl_rel_prf_code_2,
    fl.i_fl_rel_prf_code_1,
    fl.i_fl_rel_prf_code_0
  };

  dec_fl_lane_offset u_alloc_off (
    .vld (alloc_vld),
    .off (a_off),
    .cnt (a_cnt)
  );

  dec_fl_lane_offset u_rel_off (
    .vld (rel.vld),
    .off (r_off),
    .cnt (r_cnt)
  );

  assign free_cnt   = tail_q - spec_head_q;
  assign alloc_rdy  = (free_cnt >= ptr_t'(a_cnt))
                    && !fl.i_fl_flush;
  assign alloc_fire = fl.i_fl_alloc_en && alloc_rdy;

  always_comb begin
    for (int k = 0; k < FL_LANES; k++) begin
      a_idx[k] = spec_head_q[IDX_W-1:0] + idx_t'(a_off[k]);
      r_idx[k] = tail_q[IDX_W-1:0] + idx_t'(r_off[k]);
      grant[k] = entry_q[a_idx[k]];
    end
  end

  // Releases land behind the tail; granted codes are never bypassed.
  always_comb begin
    entry_d = entry_q;
    for (int k = 0; k < FL_LANES; k++) begin
      if (rel.vld[k]) begin
        entry_d[r_idx[k]] = rel.code[k];
      end
    end
  end

  always_comb begin
    cmt_head_d  = cmt_head_q + ptr_t'(r_cnt);
    tail_d      = tail_q + ptr_t'(r_cnt);
    spec_head_d = spec_head_q;
    unique case (1'b1)
      fl.i_fl_flush: spec_head_d = cmt_head_d;
      alloc_fire:    spec_head_d = spec_head_q + ptr_t'(a_cnt);
      default:       spec_head_d = spec_head_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q     <= ENTRY_RST;
      spec_head_q <= '0;
      cmt_head_q  <= '0;
      tail_q      <= ptr_t'(FL_DEPTH);
    end else begin
      entry_q     <= entry_d;
      spec_head_q <= spec_head_d;
      cmt_head_q  <= cmt_head_d;
      tail_q      <= tail_d;
    end
  end

  assign fl.o_fl_alloc_prf_code_0 = grant[0];
  assign fl.o_fl_alloc_prf_code_1 = grant[1];
  assign fl.o_fl_alloc_prf_code_2 = grant[2];
  assign fl.o_fl_alloc_prf_code_3 = grant[3];
  assign fl.o_fl_alloc_rdy        = alloc_rdy;
  assign fl.o_fl_free_cnt         = fl_cnt_t'(free_cnt);

  logic rel_zero;

  always_comb begin
    rel_zero = 1'b0;
    for (int k = 0; k < FL_LANES; k++) begin
      if (rel.vld[k] && (rel.code[k] == '0)) begin
        rel_zero = 1'b1;
      end
    end
  end

  // Retire can only free codes that were allocated earlier.
  a_rel_bound: assert property (
    @(posedge clk) disable iff (!rst_n)
    ptr_t'(r_cnt) <= (ptr_t'(FL_DEPTH) - free_cnt)
  );

  a_rel_nonzero: assert property (
    @(posedge clk) disable iff (!rst_n)
    !rel_zero
  );

endmodule

// File: tb/tb_dec_freelist_module.sv
// Scoreboard bench for the rename free list.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_dec_freelist_module;
  import dec_freelist_module_pkg::*;

  typedef logic [3:0][5:0] c4_t;

  typedef struct packed {
    int         cyc;
    logic [3:0] code_m;
    c4_t        code;
    logic       chk_rdy;
    logic       rdy;
    logic       chk_cnt;
    logic [5:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t  exp_q[$];
  string tag_q[$];

  int fl_m[$];
  int inf_rd[$];
  int inf_cd[$];
  int arat[32];
  int nalloc;
  int rd;
  int cd;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dec_freelist_module_if fl_if ();

  dec_freelist_module #(
    .FL_DEPTH (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl_if)
  );

  function automatic c4_t codes4(int a, int b, int c, int d);
    c4_t v;
    v[0] = 6'(a);
    v[1] = 6'(b);
    v[2] = 6'(c);
    v[3] = 6'(d);
    return v;
  endfunction

  task automatic drive(
    input logic [3:0] av,
    input logic       en,
    input logic [3:0] rv,
    input c4_t        rc,
    input logic       fls
  );
    fl_if.i_fl_alloc_vld_0    = av[0];
    fl_if.i_fl_alloc_vld_1    = av[1];
    fl_if.i_fl_alloc_vld_2    = av[2];
    fl_if.i_fl_alloc_vld_3    = av[3];
    fl_if.i_fl_alloc_en       = en;
    fl_if.i_fl_rel_vld_0      = rv[0];
    fl_if.i_fl_rel_vld_1      = rv[1];
    fl_if.i_fl_rel_vld_2      = rv[2];
    fl_if.i_fl_rel_vld_3      = rv[3];
    fl_if.i_fl_rel_prf_code_0 = rc[0];
    fl_if.i_fl_rel_prf_code_1 = rc[1];
    fl_if.i_fl_rel_prf_code_2 = rc[2];
    fl_if.i_fl_rel_prf_code_3 = rc[3];
    fl_if.i_fl_flush          = fls;
  endtask

  task automatic idle();
    drive(4'h0, 1'b0, 4'h0, '0, 1'b0);
  endtask

  task automatic exp_push(
    input string      tag,
    input logic [3:0] m,
    input c4_t        c,
    input logic       cr,
    input logic       r,
    input logic       cc,
    input logic [5:0] n
  );
    exp_t e;
    e.cyc     = cyc;
    e.code_m  = m;
    e.code    = c;
    e.chk_rdy = cr;
    e.rdy     = r;
    e.chk_cnt = cc;
    e.cnt     = n;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    exp_push("reset", 4'b0001, codes4(32, 0, 0, 0),
             1'b1, 1'b1, 1'b1, 6'd32);
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    string t;
    c4_t   got;
    got = {fl_if.o_fl_alloc_prf_code_3,
           fl_if.o_fl_alloc_prf_code_2,
           fl_if.o_fl_alloc_prf_code_1,
           fl_if.o_fl_alloc_prf_code_0};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e.cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s stale: queued cyc %0d seen cyc %0d",
                 t, e.cyc, cyc);
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (e.code_m[k]) begin
            n_tests++;
            if (got[k] !== e.code[k]) begin
              n_fail++;
              $display("FAIL %s lane%0d code got %0d exp %0d",
                       t, k, got[k], e.code[k]);
            end
          end
        end
        if (e.chk_rdy) begin
          n_tests++;
          if (fl_if.o_fl_alloc_rdy !== e.rdy) begin
            n_fail++;
            $display("FAIL %s rdy got %b exp %b",
                     t, fl_if.o_fl_alloc_rdy, e.rdy);
          end
        end
        if (e.chk_cnt) begin
          n_tests++;
          if (fl_if.o_fl_free_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL %s free_cnt got %0d exp %0d",
                     t, fl_if.o_fl_free_cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] av;
    logic [3:0] rv;
    c4_t        rc;
    c4_t        ec;
    rst_n = 1'b0;
    idle();
    tick();

    // Four-lane grant from reset.
    do_reset();
    drive(4'hf, 1'b1, 4'h0, '0, 1'b0);
    exp_push("a_alloc4", 4'hf, codes4(32, 33, 34, 35),
             1'b1, 1'b1, 1'b1, 6'd32);
    tick();
    idle();
    exp_push("a_after", 4'b0001, codes4(36, 0, 0, 0),
             1'b1, 1'b1, 1'b1, 6'd28);
    tick();

    // Sparse lanes compact onto consecutive entries.
    do_reset();
    drive(4'b1010, 1'b1, 4'h0, '0, 1'b0);
    exp_push("b_sparse", 4'b1010, codes4(0, 32, 0, 33),
             1'b1, 1'b1, 1'b1, 6'd32);
    tick();
    idle();
    exp_push("b_after", 4'b0001, codes4(34, 0, 0, 0),
             1'b1, 1'b1, 1'b1, 6'd30);
    tick();

    // Drain to two, refuse three, grant two, then empty.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(4'hf, 1'b1, 4'h0, '0, 1'b0);
      exp_push("c_drain", 4'b0001, codes4(32 + 4 * i, 0, 0, 0),
               1'b1, 1'b1, 1'b1, 6'(32 - 4 * i));
      tick();
    end
    drive(4'b0011, 1'b1, 4'h0, '0, 1'b0);
    exp_push("c_two", 4'b0011, codes4(60, 61, 0, 0),
             1'b1, 1'b1, 1'b1, 6'd4);
    tick();
    drive(4'b0111, 1'b1, 4'h0, '0, 1'b0);
    exp_push("c_short", 4'b0000, '0,
             1'b1, 1'b0, 1'b1, 6'd2);
    tick();
    idle();
    exp_push("c_hold", 4'b0001, codes4(62, 0, 0, 0),
             1'b1, 1'b1, 1'b1, 6'd2);
    tick();
    drive(4'b0011, 1'b1, 4'h0, '0, 1'b0);
    exp_push("c_grant2", 4'b0011, codes4(62, 63, 0, 0),
             1'b1, 1'b1, 1'b1, 6'd2);
    tick();
    drive(4'b0001, 1'b0, 4'h0, '0, 1'b0);
    exp_push("c_empty", 4'b0000, '0,
             1'b1, 1'b0, 1'b1, 6'd0);
    tick();

    // Alloc 8, retire 5/6/7, flush; released codes follow 63.
    do_reset();
    drive(4'hf, 1'b1, 4'h0, '0, 1'b0);
    exp_push("d_alloc0", 4'hf, codes4(32, 33, 34, 35),
             1'b1, 1'b1, 1'b1, 6'd32);
    tick();
    drive(4'hf, 1'b1, 4'h0, '0, 1'b0);
    exp_push("d_alloc1", 4'hf, codes4(36, 37, 38, 39),
             1'b1, 1'b1, 1'b1, 6'd28);
    tick();
    drive(4'h0, 1'b0, 4'b0111, codes4(5, 6, 7, 0), 1'b0);
    exp_push("d_retire", 4'h0, '0, 1'b0, 1'b0, 1'b1, 6'd24);
    tick();
    drive(4'h0, 1'b0, 4'h0, '0, 1'b1);
    exp_push("d_flush", 4'h0, '0, 1'b1, 1'b0, 1'b1, 6'd27);
    tick();
    idle();
    exp_push("d_rewind", 4'b0001, codes4(35, 0, 0, 0),
             1'b1, 1'b1, 1'b1, 6'd32);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(4'hf, 1'b1, 4'h0, '0, 1'b0);
      exp_push("d_run", 4'hf,
               codes4(35 + 4 * i, 36 + 4 * i, 37 + 4 * i, 38 + 4 * i),
               1'b1, 1'b1, 1'b1, 6'(32 - 4 * i));
      tick();
    end
    drive(4'hf, 1'b1, 4'h0, '0, 1'b0);
    exp_push("d_wrap", 4'hf, codes4(63, 5, 6, 7),
             1'b1, 1'b1, 1'b1, 6'd4);
    tick();
    idle();
    exp_push("d_end", 4'h0, '0, 1'b1, 1'b1, 1'b1, 6'd0);
    tick();

    // Flush, release and alloc_en in one cycle.
    do_reset();
    drive(4'hf, 1'b1, 4'h0, '0, 1'b0);
    exp_push("e_alloc", 4'hf, codes4(32, 33, 34, 35),
             1'b1, 1'b1, 1'b1, 6'd32);
    tick();
    drive(4'hf, 1'b1, 4'b0011, codes4(9, 10, 0, 0), 1'b1);
    exp_push("e_flush_rel", 4'h0, '0, 1'b1, 1'b0, 1'b1, 6'd28);
    tick();
    drive(4'hf, 1'b1, 4'h0, '0, 1'b0);
    exp_push("e_after", 4'hf, codes4(34, 35, 36, 37),
             1'b1, 1'b1, 1'b1, 6'd32);
    tick();

    // Tail wrap: 40 cycles of 4 allocs + 4 retires against a FIFO model.
    do_reset();
    fl_m.delete();
    inf_rd.delete();
    inf_cd.delete();
    for (int i = 32; i < 64; i++) fl_m.push_back(i);
    for (int r = 0; r < 32; r++) arat[r] = r;
    nalloc = 0;
    for (int c = 0; c < 41; c++) begin
      av = (c < 40) ? 4'hf : 4'h0;
      rv = 4'h0;
      rc = '0;
      ec = '0;
      if (inf_rd.size() >= 4) begin
        rv = 4'hf;
        for (int k = 0; k < 4; k++) begin
          rd = inf_rd.pop_front();
          cd = inf_cd.pop_front();
          rc[k] = 6'(arat[rd]);
          arat[rd] = cd;
        end
      end
      if (av[0]) begin
        for (int k = 0; k < 4; k++) ec[k] = 6'(fl_m[k]);
      end
      drive(av, 1'b1, rv, rc, 1'b0);
      exp_push("f_wrap", av, ec, 1'b1, 1'b1, 1'b1,
               6'(fl_m.size()));
      tick();
      if (av[0]) begin
        for (int k = 0; k < 4; k++) begin
          cd = fl_m.pop_front();
          inf_rd.push_back((nalloc % 31) + 1);
          inf_cd.push_back(cd);
          nalloc++;
        end
      end
      if (rv[0]) begin
        for (int k = 0; k < 4; k++) fl_m.push_back(int'(rc[k]));
      end
    end
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) ec[k] = 6'(fl_m[k]);
      drive(4'hf, 1'b1, 4'h0, '0, 1'b0);
      exp_push("f_drain", 4'hf, ec, 1'b1, 1'b1, 1'b1,
               6'(fl_m.size()));
      tick();
      for (int k = 0; k < 4; k++) void'(fl_m.pop_front());
    end
    idle();
    exp_push("f_empty", 4'h0, '0, 1'b1, 1'b1, 1'b1, 6'd0);
    tick();

    tick();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, need 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_freelist_module.md
DEC_FREELIST_MODULE -- requirements
Module: dec_freelist_module

Interface
REQ-001 SHALL declare parameter FL_DEPTH, default 32, meaning the number of free-list entries (physical registers 64 minus 32 architectural).
REQ-002 SHALL declare clk  input  1  core clock.
REQ-003 SHALL declare rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL declare i_fl_alloc_vld_0..3  input  1 each  rename lane k needs a destination PRF.
REQ-005 SHALL declare i_fl_alloc_en  input  1  rename group fires this cycle.
REQ-006 SHALL declare o_fl_alloc_prf_code_0..3  output  PRF_CODE_WIDTH each  PRF code granted to lane k.
REQ-007 SHALL declare o_fl_alloc_rdy  output  1  enough free entries for every valid alloc lane.
REQ-008 SHALL declare i_fl_rel_vld_0..3  input  1 each  retire lane k wrote the architectural rename table (ARAT) with rd != x0.
REQ-009 SHALL declare i_fl_rel_prf_code_0..3  input  PRF_CODE_WIDTH each  old mapping returned by the ARAT for lane k.
REQ-010 SHALL declare i_fl_flush  input  1  pipeline flush; speculative allocations are discarded.
REQ-011 SHALL declare o_fl_free_cnt  output  6  current speculative free count, 0..32.

Function
REQ-012 SHALL hold storage as a circular buffer of FL_DEPTH entries, each PRF_CODE_WIDTH bits wide.
REQ-013 SHALL keep three 6-bit pointers (5-bit index plus wrap bit): spec_head, cmt_head and tail.
REQ-014 SHALL compute A = popcount(alloc_vld) and R = popcount(rel_vld).
REQ-015 SHALL drive o_fl_free_cnt = tail - spec_head (modulo 64).
REQ-016 SHALL compact lanes: lane k code = entry[spec_head + popcount(alloc_vld lanes < k)]; the code is combinational from current state, with zero-cycle latency.
REQ-017 SHALL assert o_fl_alloc_rdy iff o_fl_free_cnt >= A and i_fl_flush = 0.
REQ-018 SHALL advance spec_head by A at the clock edge iff i_fl_alloc_en & o_fl_alloc_rdy; otherwise spec_head is unchanged and there are no partial grants.
REQ-019 SHALL write each valid release lane, compacted in lane order, to entry[tail + prefix], and advance tail by R on the same edge.
REQ-020 SHALL advance cmt_head by R each cycle, because every retire that frees an old mapping consumed one allocation.
REQ-021 SHALL, on i_fl_flush, set spec_head := cmt_head + R, which equals the updated cmt_head; o_fl_free_cnt is then exactly 32 in the following cycle.
REQ-022 SHALL, when allocation and release occur in the same cycle, apply both; an allocation sees only the pre-edge free count, with no same-cycle bypass of released codes.
REQ-023 SHALL, when flush and release occur in the same cycle, process the release before the rewind; the allocation is ignored.
REQ-024 SHALL wrap all pointer arithmetic modulo 64; full is (tail - spec_head) = 32 and empty is tail == spec_head.
REQ-025 SHALL treat R > (32 - o_fl_free_cnt), or a released code of 0, as illegal; these are simulation assertions only, with no RTL guard.

Reset
REQ-026 SHALL, on rst_n low, immediately set entry[i] = 32 + i for i = 0..31, spec_head = cmt_head = 0, and tail = 32 (wrap=1, index 0).
REQ-027 SHALL, while in reset, drive o_fl_free_cnt = 32, o_fl_alloc_rdy = 1 (with i_fl_flush = 0), and o_fl_alloc_prf_code_0 = 32.
REQ-028 SHALL abandon any pending allocation or release on reset mid-operation, with no recovery.

Structure
REQ-029 SHALL take PRF_CODE_WIDTH (6), ARF_CODE_WIDTH (5) and FL_DEPTH from the shared core define header; no local redefinition.
REQ-030 SHALL build entries and pointers from the existing reset-capable general DFF primitives.
REQ-031 SHALL place 4-lane prefix-count/popcount logic in one sub-module, dec_fl_lane_offset, instantiated twice (alloc, release).

Verification
REQ-032 SHALL cover: after reset, alloc_vld = 4'b1111 with en -> codes 32, 33, 34, 35; next cycle free_cnt = 28.
REQ-033 SHALL cover: alloc_vld = 4'b1010 with en from reset -> lane1 = 32, lane3 = 33, free_cnt = 30; lanes 0 and 2 are don't-care.
REQ-034 SHALL cover: drain to free_cnt = 2, then request 3 lanes -> rdy = 0, no pointer change; a 2-lane request -> granted.
REQ-035 SHALL cover: alloc 8 (codes 32..39), retire 3 releasing codes 5, 6, 7, then flush -> free_cnt = 32, next alloc lane0 = 35, and codes 5, 6, 7 appear after code 63.
REQ-036 SHALL cover: tail wrap: 40 alloc/release cycles of 4 lanes each -> no code lost or duplicated; a scoreboard confirms the set {free} ∪ {ARAT} ∪ {in-flight} always equals 1..63.
REQ-037 SHALL cover: flush, release of 2 codes and alloc_en all in one cycle -> release applied, allocation ignored, free_cnt = 32 next cycle.
